// File: rtl/uart_rx_fifo_if.sv
// Pop-side bundle of the UART receive FIFO: head data, pop handshake, occupancy and sticky errors.
// Handshake: the head entry is popped on any clock where rvalid && rready; rdata is meaningful only while rvalid=1.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rdata;
  logic          rvalid;
  logic          rready;
  logic          pending;
  logic [CW-1:0] count;
  logic          framing_err;
  logic          overrun;
  logic          err_clear;

  modport master (
    output rdata, rvalid, pending, count, framing_err, overrun,
    input  rready, err_clear
  );

  modport slave (
    input  rdata, rvalid, pending, count, framing_err, overrun,
    output rready, err_clear
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO.
// The FIFO raises sticky framing/overrun flags that the reader clears.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  output logic [1:0]     dbg_state,
  uart_rx_fifo_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PW           = $clog2(FIFO_DEPTH);
  localparam int CW           = PW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             framing_err;

  logic             rx_meta;
  logic             rxs;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             overrun;

  logic             stop_hit;
  logic             push;
  logic             pop;
  logic             accept;
  logic             rvalid;

  // Both stages reset high so a reset never looks like a start edge by itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign stop_hit = (state == S_STOP) && (cnt == BIT_LAST);
  assign push     = stop_hit && rxs;
  assign rvalid   = (count != '0);
  assign pop      = rvalid && bus.rready;
  assign accept   = push && ((count < DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      framing_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A new error outranks a simultaneous clear.
      if (stop_hit && !rxs)   framing_err <= 1'b1;
      else if (bus.err_clear) framing_err <= 1'b0;
    end
  end

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept)    overrun <= 1'b1;
      else if (bus.err_clear) overrun <= 1'b0;
    end
  end

  assign bus.rdata       = mem[rd_ptr];
  assign bus.rvalid      = rvalid;
  assign bus.pending     = rvalid;
  assign bus.count       = count;
  assign bus.framing_err = framing_err;
  assign bus.overrun     = overrun;
  assign dbg_state       = state;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit with a 4-entry FIFO.
// Sent bytes that must land in the FIFO go into exp_q and are checked when popped.
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;
  localparam int CPB   = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [1:0] dbg_state;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .dbg_state(dbg_state),
    .bus      (bus)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] next_exp();
    logic [7:0] e;
    e = 8'hxx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Called at a negedge; pops the head and checks it against the scoreboard.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = next_exp();
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'(e));
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  // Drives one 8N1 frame starting at the current negedge; returns 160 cycles later.
  // The push/stop-sample clock edge is the one following the 154th negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input bit pop_at_stop, input bit clr_at_stop, input bit chk_lat);
    logic [7:0] e;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_val;
    repeat (10) @(negedge clk);
    if (chk_lat) chk("lat_before_push", 32'(bus.rvalid), 32'd0);
    if (pop_at_stop) begin
      e = next_exp();
      chk("pop_in_push_rdata", 32'(bus.rdata), 32'(e));
      bus.rready = 1'b1;
    end
    if (clr_at_stop) bus.err_clear = 1'b1;
    @(negedge clk);
    bus.rready    = 1'b0;
    bus.err_clear = 1'b0;
    if (chk_lat) begin
      chk("lat_after_push", 32'(bus.rvalid), 32'd1);
      chk("lat_pending", 32'(bus.pending), 32'd1);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_clear();
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
  endtask

  initial begin
    bus.rready    = 1'b0;
    bus.err_clear = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ferr", 32'(bus.framing_err), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // single byte with push-latency check
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'hA5);
    chk("single_count", 32'(bus.count), 32'd1);
    pop_check("single");
    chk("single_empty_rvalid", 32'(bus.rvalid), 32'd0);
    chk("single_empty_pending", 32'(bus.pending), 32'd0);
    chk("single_empty_count", 32'(bus.count), 32'd0);

    // back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    chk("b2b_count", 32'(bus.count), 32'd3);
    pop_check("b2b0");
    pop_check("b2b1");
    pop_check("b2b2");
    chk("b2b_drained", 32'(bus.count), 32'd0);

    // glitch shorter than half a bit
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_in_start", 32'(dbg_state), 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_state", 32'(dbg_state), 32'd0);
    chk("glitch_count", 32'(bus.count), 32'd0);
    chk("glitch_ferr", 32'(bus.framing_err), 32'd0);
    chk("glitch_ovr", 32'(bus.overrun), 32'd0);

    // framing error, with err_clear coinciding with the bad stop sample
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_count", 32'(bus.count), 32'd0);
    chk("ferr_set", 32'(bus.framing_err), 32'd1);
    chk("ferr_no_ovr", 32'(bus.overrun), 32'd0);
    pulse_clear();
    chk("ferr_cleared", 32'(bus.framing_err), 32'd0);

    // overrun: five bytes into four slots
    for (int i = 0; i < 5; i++) begin
      send_frame(8'(8'h11 * (i + 1)), 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < DEPTH) exp_q.push_back(8'(8'h11 * (i + 1)));
    end
    chk("ovr_count", 32'(bus.count), 32'd4);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_no_ferr", 32'(bus.framing_err), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_check("ovr_pop");
    chk("ovr_drained", 32'(bus.count), 32'd0);
    pulse_clear();
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);

    // full FIFO, pop lands in the same cycle as the fifth push
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'(8'hC0 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'(8'hC0 + i));
    end
    chk("full_count", 32'(bus.count), 32'd4);
    send_frame(8'h9E, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h9E);
    chk("poppush_count", 32'(bus.count), 32'd4);
    chk("poppush_no_ovr", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_check("poppush_pop");
    chk("poppush_drained", 32'(bus.count), 32'd0);

    // reset in the middle of a frame, with data and a flag pending
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("prerst_count", 32'(bus.count), 32'd1);
    chk("prerst_ferr", 32'(bus.framing_err), 32'd1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_in_data", 32'(dbg_state), 32'd2);
    rx    = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("midrst_ferr", 32'(bus.framing_err), 32'd0);
    chk("midrst_ovr", 32'(bus.overrun), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h81);
    chk("after_rst_count", 32'(bus.count), 32'd1);
    pop_check("after_rst");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
